if_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipeline: owns the PC, drives the instruction-memory read handshake, and presents a fetched instruction with its PC and PC+4 to the IF/ID pipeline register. Absorbs hazard-unit stalls with a one-entry hold buffer. Applies branch/jump redirects, including redirects that arrive while an instruction-memory read cannot be aborted.

---
 rtl/rv32i_types.sv | 27 ++
 rtl/if_perf_ctr.sv | 19 +
 rtl/if_stage.sv | 161 ++++++++++++++++
 tb/tb_if_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM states,
// NOP encoding and the IF/ID bundle.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0060;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
  } if_id_t;

  function automatic logic [31:0] pc_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_perf_ctr.sv
// Saturating 32-bit event counter; sticks at all-ones.
// Used by if_stage when IF_STAGE_PERF_EN is defined.
module if_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  // count events, holding at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (inc && !(&count)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, imem handshake, stall hold, redirects.
// Optional perf counters under IF_STAGE_PERF_EN.
import rv32i_types::*;

module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_4_o
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_kill_o,
  output logic [31:0] perf_stall_o
`endif
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] buf_instr;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;
  logic        st_fetch;
  logic        st_kill;
  logic        st_hold;
  logic        fetch_read;
  if_id_t      if_out;

  assign redir_pc = pc_align(redirect_pc_i);
  assign pc_inc   = pc + 32'd4;
  assign st_fetch = (state == FETCH);
  assign st_kill  = (state == KILL);
  assign st_hold  = (state == HOLD);

  // PC / FSM update; redirect always wins over stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend_pc   <= 32'd0;
      buf_instr <= RV32I_NOP;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_resp) begin
            if (redirect_i) begin
              pc <= redir_pc;
            end else if (!stall_i) begin
              pc <= pc_inc;
            end else begin
              buf_instr <= imem_rdata;
              state     <= HOLD;
            end
          end else if (redirect_i) begin
            pend_pc <= redir_pc;
            state   <= KILL;
          end
        end
        KILL: begin
          if (imem_resp) begin
            pc    <= redirect_i ? redir_pc : pend_pc;
            state <= FETCH;
          end else if (redirect_i) begin
            pend_pc <= redir_pc;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc    <= redir_pc;
            state <= FETCH;
          end else if (!stall_i) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // request is held until the response pulse
  always_comb begin
    fetch_read = 1'b0;
    unique case (1'b1)
      st_fetch: fetch_read = 1'b1;
      st_kill:  fetch_read = 1'b1;
      default:  fetch_read = 1'b0;
    endcase
  end

  assign imem_read    = fetch_read & rst_n;
  assign imem_address = pc_align(pc);

  // IF/ID bundle: live data, held data, or a bubble
  always_comb begin
    if_out.valid = 1'b0;
    if_out.instr = RV32I_NOP;
    if_out.pc    = pc;
    if_out.pc_4  = pc_inc;
    unique case (1'b1)
      st_fetch: begin
        if (imem_resp && !redirect_i) begin
          if_out.valid = 1'b1;
          if_out.instr = imem_rdata;
        end
      end
      st_hold: begin
        if_out.valid = 1'b1;
        if_out.instr = buf_instr;
      end
      default: ;
    endcase
  end

  assign valid_o = if_out.valid;
  assign instr_o = if_out.instr;
  assign pc_o    = if_out.pc;
  assign pc_4_o  = if_out.pc_4;

`ifdef IF_STAGE_PERF_EN
  logic inc_fetch;
  logic inc_kill;
  logic inc_stall;

  assign inc_fetch = if_out.valid & ~stall_i & ~redirect_i;
  assign inc_kill  = imem_resp & (st_kill | (st_fetch & redirect_i));
  assign inc_stall = st_hold & stall_i;

  if_perf_ctr u_perf_fetch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_fetch),
    .count (perf_fetch_o)
  );

  if_perf_ctr u_perf_kill (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_kill),
    .count (perf_kill_o)
  );

  if_perf_ctr u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_stall),
    .count (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural fetch model,
// variable-latency memory and literal pins.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_kill_o;
  logic [31:0] perf_stall_o;
`endif

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .imem_resp     (imem_resp),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_kill_o   (perf_kill_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // memory
  bit          busy;
  logic [31:0] maddr;
  int          mcnt;
  int          lat = 1;

  // model
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_disc;
  logic [31:0] hq[$];
  int unsigned c_fetch, c_kill, c_stall;

  // samples
  logic        s_read, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0093;
    if (a == 32'h64) return 32'h0020_8133;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sample();
    s_read  = imem_read;
    s_addr  = imem_address;
    s_valid = valid_o;
    s_instr = instr_o;
    s_pc    = pc_o;
    s_pc4   = pc_4_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    imem_resp = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    sample();
    chk("rst_read", {31'd0, s_read}, 32'd0);
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_instr", s_instr, 32'h0000_0013);
    chk("rst_pc", s_pc, 32'h60);
    chk("rst_pc4", s_pc4, 32'h64);
`ifdef IF_STAGE_PERF_EN
    chk("rst_perf", perf_fetch_o | perf_kill_o | perf_stall_o, 32'd0);
`endif
    busy = 0;
    m_pc = 32'h60;
    m_tgt = 32'd0;
    m_disc = 0;
    hq.delete();
    c_fetch = 0;
    c_kill = 0;
    c_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit st, input bit rd,
                       input logic [31:0] rpc);
    bit          resp;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] tgt;
    @(negedge clk);
    resp = busy && (mcnt == 0);
    imem_resp = resp;
    imem_rdata = resp ? word(maddr) : 32'hDEAD_BEEF;
    stall_i = st;
    redirect_i = rd;
    redirect_pc_i = rpc;
    #1;
    sample();
    tgt = rpc & 32'hFFFF_FFFC;
    if (hq.size() > 0) begin
      e_valid = 1;
      e_instr = hq[0];
    end else if (resp && !m_disc && !rd) begin
      e_valid = 1;
      e_instr = word(m_pc);
    end else begin
      e_valid = 0;
      e_instr = 32'h0000_0013;
    end
    chk("read", {31'd0, s_read}, {31'd0, hq.size() == 0});
    chk("addr", s_addr, m_pc);
    chk("valid", {31'd0, s_valid}, {31'd0, e_valid});
    chk("instr", s_instr, e_instr);
    chk("pc", s_pc, m_pc);
    chk("pc4", s_pc4, m_pc + 32'd4);
`ifdef IF_STAGE_PERF_EN
    chk("perf_fetch", perf_fetch_o, c_fetch);
    chk("perf_kill", perf_kill_o, c_kill);
    chk("perf_stall", perf_stall_o, c_stall);
`endif
    if (e_valid && !st && !rd) c_fetch++;
    if (resp && (m_disc || rd)) c_kill++;
    if (hq.size() > 0 && st) c_stall++;
    if (hq.size() > 0) begin
      if (rd) begin
        m_pc = tgt;
        hq.delete();
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
        hq.delete();
      end
    end else if (m_disc) begin
      if (resp) begin
        m_pc = rd ? tgt : m_tgt;
        m_disc = 0;
      end else if (rd) begin
        m_tgt = tgt;
      end
    end else if (resp) begin
      if (rd) m_pc = tgt;
      else if (!st) m_pc = m_pc + 32'd4;
      else hq.push_back(word(m_pc));
    end else if (rd) begin
      m_disc = 1;
      m_tgt = tgt;
    end
    if (resp) busy = 0;
    else if (busy) mcnt--;
    else if (s_read) begin
      busy = 1;
      maddr = s_addr;
      mcnt = lat - 1;
    end
  endtask

  initial begin
    do_reset();
    lat = 1;
    cycle(0, 0, 0);
    chk("p_addr60", s_addr, 32'h60);
    chk("p_read1", {31'd0, s_read}, 32'd1);
    cycle(0, 0, 0);
    chk("p_valid", {31'd0, s_valid}, 32'd1);
    chk("p_instr93", s_instr, 32'h93);
    chk("p_pc60", s_pc, 32'h60);
    chk("p_pc4_64", s_pc4, 32'h64);
    cycle(0, 0, 0);
    chk("p_addr64", s_addr, 32'h64);
    cycle(1, 0, 0);
    chk("p_stall_valid", {31'd0, s_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      chk("p_hold_read", {31'd0, s_read}, 32'd0);
      chk("p_hold_instr", s_instr, 32'h0020_8133);
    end
    cycle(0, 0, 0);
    chk("p_release", s_instr, 32'h0020_8133);
    lat = 3;
    cycle(0, 0, 0);
    chk("p_addr68", s_addr, 32'h68);
    cycle(0, 1, 32'h200);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("p_kill_valid", {31'd0, s_valid}, 32'd0);
    chk("p_kill_instr", s_instr, 32'h13);
    cycle(0, 0, 0);
    chk("p_addr200", s_addr, 32'h200);
    cycle(0, 1, 32'h300);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h400);
    lat = 1;
    cycle(0, 0, 0);
    chk("p_addr400", s_addr, 32'h400);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h500);
    chk("p_hold_rd", {31'd0, s_valid}, 32'd1);
    cycle(0, 0, 0);
    chk("p_drop_valid", {31'd0, s_valid}, 32'd0);
    chk("p_addr500", s_addr, 32'h500);
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    chk("p_addr_top", s_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    chk("p_wrap_pc4", s_pc4, 32'h0);
    cycle(0, 0, 0);
    chk("p_addr0", s_addr, 32'h0);
    cycle(0, 1, 32'h103);
    cycle(0, 0, 0);
    chk("p_addr100", s_addr, 32'h100);
    for (int i = 0; i < 120; i++) begin
      lat = $urandom_range(1, 3);
      cycle($urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0,
            $urandom);
    end
    begin
      int n;
      n = 0;
      while (hq.size() == 0 && n < 30) begin
        lat = 1;
        cycle(1, 0, 0);
        n++;
      end
      chk("reach_hold", {31'd0, hq.size() > 0}, 32'd1);
    end
    do_reset();
    cycle(0, 0, 0);
    chk("p_restart", s_addr, 32'h60);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
